// File: rtl/mem_bus_slave.sv
// Slow-memory responder: valid/ready request in, wait states, one array access, held response out.
// Misaligned or out-of-range requests skip the array and answer immediately with rsp_err.
module mem_bus_slave #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     wait_cnt;
  logic              write_q;
  logic [ADDR_W-1:0] word_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              addr_err;

  logic [WIDTH-1:0] mem [0:(1 << ADDR_W) - 1];

  // Any address bit above the word index makes the request out of range.
  assign addr_err  = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_W + 2)) != '0);

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign req_ready = (state == S_IDLE) && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (addr_err) begin
            state_nxt = S_RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt  <= '0;
      write_q   <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            word_q    <= req_addr[ADDR_W+1:2];
            wdata_q   <= req_wdata;
            wait_cnt  <= WAIT_LOAD;
            rsp_rdata <= '0;
            rsp_err   <= addr_err;
            if (addr_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_ACCESS: begin
          rsp_rdata <= write_q ? '0 : mem[word_q];
          rsp_err   <= 1'b0;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The array has no reset; an asynchronous reset forces state out of ACCESS, so no write lands.
  always_ff @(posedge clk) begin
    if ((state == S_ACCESS) && write_q) begin
      mem[word_q] <= wdata_q;
    end
  end

endmodule
